// File: rtl/host_pkg.sv
// Shared constants and types for the banner host: clock default, banner ROM
// contents and the sequencer state encoding.
package host_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int BAUD_DEFAULT   = 115200;
    localparam int BANNER_LEN     = 13;

    // Index of the last banner byte; idx never moves beyond this value.
    localparam logic [3:0] LAST_IDX = 4'd12;

    // "Hello, Z80!\r\n"
    localparam logic [7:0] BANNER [BANNER_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
        8'h5A, 8'h38, 8'h30, 8'h21, 8'h0D, 8'h0A
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Banner ROM lookup; out-of-range indices return an all-ones byte.
    function automatic logic [7:0] banner_byte(input logic [3:0] idx);
        logic [7:0] b;
        if (idx < 4'(BANNER_LEN)) begin
            b = BANNER[idx];
        end else begin
            b = 8'hFF;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_core.sv
// 8N1 serializer. A write while idle latches the byte and starts the frame on
// the next clock; busy stays high until the stop bit has been held DIV clocks.
module uart_core #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] baud_cnt_r;
    logic [3:0]    bit_cnt_r;
    logic [8:0]    shift_r;
    logic          busy_r;
    logic          tx_r;
    logic          bit_end_s;

    assign bit_end_s = (baud_cnt_r == DIV_LAST);

    // Frame engine: start bit on accept, then 8 data bits LSB first, then stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt_r <= {CW{1'b0}};
            bit_cnt_r  <= 4'd0;
            shift_r    <= 9'h1FF;
            busy_r     <= 1'b0;
            tx_r       <= 1'b1;
        end else if (!busy_r) begin
            if (we) begin
                busy_r     <= 1'b1;
                tx_r       <= 1'b0;
                shift_r    <= {1'b1, data};
                baud_cnt_r <= {CW{1'b0}};
                bit_cnt_r  <= 4'd0;
            end else begin
                tx_r <= 1'b1;
            end
        end else if (bit_end_s) begin
            baud_cnt_r <= {CW{1'b0}};
            if (bit_cnt_r == 4'd9) begin
                busy_r <= 1'b0;
                tx_r   <= 1'b1;
            end else begin
                tx_r      <= shift_r[0];
                shift_r   <= {1'b1, shift_r[8:1]};
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
        end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1'b1);
        end
    end

    assign busy = busy_r;
    assign tx   = tx_r;

endmodule

// File: rtl/uart_io.sv
// Byte-write UART port: one-cycle we with data, busy back. Wraps the 8N1
// serializer whose BAUD parameter sets the bit rate.
module uart_io #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    uart_core #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) uart_core_ (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .data  (data),
        .busy  (busy),
        .tx    (tx)
    );

endmodule

// File: rtl/host.sv
// Banner host: after reset, sends "Hello, Z80!\r\n" once over the UART and
// then parks with the line idle high.
module host
    import host_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int BAUD   = BAUD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic uart_tx
);

    seq_state_t state_r;
    seq_state_t state_next_s;
    logic [3:0] idx_r;
    logic [3:0] idx_next_s;
    logic       we_s;
    logic       busy_s;
    logic       tx_s;
    logic [7:0] data_s;

    assign data_s = banner_byte(idx_r);

    // Sequencer state and banner index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Next-state logic: issue one write per byte, advance when the UART frees up.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        we_s         = 1'b0;
        case (state_r)
            IDLE: begin
                state_next_s = LOAD;
            end
            LOAD: begin
                we_s         = 1'b1;
                state_next_s = WAIT;
            end
            WAIT: begin
                if (!busy_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = LOAD;
                        idx_next_s   = idx_r + 4'd1;
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                state_next_s = DONE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    uart_io #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) uart_io_ (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .data  (data_s),
        .busy  (busy_s),
        .tx    (tx_s)
    );

    // tx_s comes straight from a flop inside the serializer.
    assign uart_tx = tx_s;

endmodule

// File: tb/tb_host.sv
// Bench for host: a free-running UART decoder pops expected banner bytes from
// a scoreboard queue filled by the stimulus process at each reset release.
module tb_host;

    localparam int CLK_HZ    = 50_000_000;
    localparam int BAUD_FAST = 500000;
    localparam int DIV_F     = CLK_HZ / BAUD_FAST;
    localparam int DIV_D     = CLK_HZ / 115200;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;
    logic tx;
    logic tx2;

    always #5 clk = ~clk;

    host #(.CLK_HZ(CLK_HZ), .BAUD(BAUD_FAST)) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_tx (tx)
    );

    host dut_def (
        .clk     (clk),
        .reset   (reset2),
        .uart_tx (tx2)
    );

    string banner_str = "Hello, Z80!\r\n";

    int n_cmp = 0;
    int n_bad = 0;
    byte unsigned exp_q[$];
    byte unsigned exp2_q[$];

    int   cyc = 0;
    int   n_dec = 0;
    int   n_starts = 0;
    bit   mon_active = 1'b0;
    int   mon_bit = 0;
    int   mon_cnt = 0;
    logic mon_val = 1'b0;
    bit   mon_glitch = 1'b0;
    logic [9:0] mon_bits = 10'd0;
    logic prev_tx = 1'b1;
    int   rel_cyc = 0;
    bit   first_after_rel = 1'b1;
    int   last_start = 0;
    bit   rst_tx_bad = 1'b0;
    bit   done2 = 1'b0;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_banner();
        for (int i = 0; i < banner_str.len(); i++) begin
            exp_q.push_back(banner_str[i]);
        end
    endtask

    task automatic wait_dec(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_dec < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, n_dec == target, n_dec, target);
    endtask

    // Monitor: decode the fast instance's serial line and score each byte.
    initial begin
        byte unsigned got;
        byte unsigned e;
        int d;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                mon_active      = 1'b0;
                first_after_rel = 1'b1;
                rel_cyc         = cyc;
                n_dec           = 0;
                prev_tx         = tx;
                if (tx !== 1'b1) rst_tx_bad = 1'b1;
            end else begin
                if (mon_active) begin
                    if (mon_cnt == DIV_F) begin
                        mon_bits[mon_bit] = mon_val;
                        mon_bit++;
                        if (mon_bit == 10) begin
                            mon_active = 1'b0;
                            chk("frame_shape", mon_bits[0] == 1'b0 && mon_bits[9] == 1'b1 && !mon_glitch,
                                {mon_glitch, mon_bits}, 10'h200);
                            got = mon_bits[8:1];
                            if (exp_q.size() == 0) begin
                                chk("unexpected_byte", 1'b0, got, -1);
                            end else begin
                                e = exp_q.pop_front();
                                chk("byte", got == e, got, e);
                            end
                            n_dec++;
                            prev_tx = 1'b1;
                        end else begin
                            mon_val = tx;
                            mon_cnt = 1;
                        end
                    end else begin
                        if (tx !== mon_val) mon_glitch = 1'b1;
                        mon_cnt++;
                    end
                end
                if (!mon_active) begin
                    if (prev_tx === 1'b1 && tx === 1'b0) begin
                        n_starts++;
                        if (first_after_rel) begin
                            d = cyc - rel_cyc;
                            chk("first_start_latency", d <= 5, d, 5);
                            first_after_rel = 1'b0;
                        end else begin
                            d = cyc - last_start;
                            chk("start_spacing", d >= 10 * DIV_F && d <= 10 * DIV_F + 2, d, 10 * DIV_F + 2);
                        end
                        last_start = cyc;
                        mon_active = 1'b1;
                        mon_bit    = 0;
                        mon_cnt    = 1;
                        mon_val    = 1'b0;
                        mon_glitch = 1'b0;
                    end
                    prev_tx = tx;
                end
            end
        end
    end

    // Default-rate instance: decode the first frame and check the start run.
    initial begin
        int k;
        int lowrun;
        int exp_run;
        bit still_low;
        bit g;
        logic v;
        logic [9:0] bits;
        byte unsigned e2;
        repeat (3) @(posedge clk);
        #2 reset2 = 1'b0;
        exp2_q.push_back(banner_str[0]);
        k = 0;
        while (tx2 !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("def_first_start", tx2 === 1'b0, k, 5);
        lowrun    = 0;
        still_low = 1'b1;
        g         = 1'b0;
        bits      = 10'd0;
        for (int b = 0; b < 10; b++) begin
            v = tx2;
            for (int j = 0; j < DIV_D; j++) begin
                if (j > 0) @(negedge clk);
                if (tx2 !== v) g = 1'b1;
                if (still_low && tx2 === 1'b0) lowrun++;
                else still_low = 1'b0;
            end
            bits[b] = v;
            @(negedge clk);
        end
        e2 = exp2_q.pop_front();
        exp_run = DIV_D;
        for (int b = 0; b < 8; b++) begin
            if (((e2 >> b) & 8'd1) != 8'd0) break;
            exp_run += DIV_D;
        end
        chk("def_frame_shape", bits[0] == 1'b0 && bits[9] == 1'b1 && !g, {g, bits}, 10'h200);
        chk("def_byte", bits[8:1] == e2, bits[8:1], e2);
        chk("def_start_low_run", lowrun == exp_run, lowrun, exp_run);
        done2 = 1'b1;
    end

    // Stimulus: reset phases, random hold lengths, mid-frame reset.
    initial begin
        int s;
        int k;
        @(posedge clk);
        #2 rst_tx_bad = 1'b0;

        // Long reset, then the full banner followed by a quiet line.
        repeat (1000 + $urandom_range(0, 20)) @(posedge clk);
        #2;
        chk("tx_high_in_reset", !rst_tx_bad, rst_tx_bad, 0);
        push_banner();
        reset = 1'b0;
        wait_dec(13, 14000, "banner_complete");
        s = n_starts;
        repeat (20000) @(posedge clk);
        chk("idle_no_start", n_starts == s, n_starts - s, 0);
        chk("idle_line_high", tx === 1'b1, tx, 1);

        // Restart, then abort during a zero data bit of byte 5.
        @(posedge clk);
        #2 reset = 1'b1;
        rst_tx_bad = 1'b0;
        repeat ($urandom_range(5, 50)) @(posedge clk);
        #2;
        chk("tx_high_in_reset2", !rst_tx_bad, rst_tx_bad, 0);
        push_banner();
        reset = 1'b0;
        k = 0;
        while (!(n_dec == 4 && mon_active && mon_bit == 5) && k < 8000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_byte5_bit4", n_dec == 4 && mon_bit == 5, n_dec * 16 + mon_bit, 4 * 16 + 5);
        repeat ($urandom_range(0, DIV_F - 10)) @(posedge clk);
        #2;
        chk("mid_bit_level", tx === 1'b0, tx, 0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_reset_tx", tx === 1'b1, tx, 1);
        rst_tx_bad = 1'b0;
        repeat ($urandom_range(3, 30)) @(posedge clk);
        #2;
        chk("tx_high_in_reset3", !rst_tx_bad, rst_tx_bad, 0);
        push_banner();
        reset = 1'b0;
        wait_dec(13, 14000, "banner_after_abort");
        chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);

        k = 0;
        while (!done2 && k < 10000) begin
            @(posedge clk);
            k++;
        end
        chk("def_instance_done", done2, done2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/host.md
HOST -- requirements
Module: host

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD (on instance uart_io_.uart_core_), default 115200, serial bit rate, overridable by hierarchical defparam.
REQ-003 clk  input  1  system clock, rising-edge active; one clock only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 uart_tx  output  1  serial transmit line, 8N1, idle high.

Function
REQ-006 After reset release the block SHALL transmit the fixed 13-byte banner "Hello, Z80!\r\n" once, in order.
- Bytes: 0x48 65 6C 6C 6F 2C 20 5A 38 30 21 0D 0A.
REQ-007 Bit period SHALL be DIV = CLK_HZ / BAUD clocks, integer truncated.
- 50 MHz / 500000 gives DIV = 100.
- 50 MHz / 115200 gives DIV = 434.
REQ-008 Frame format:
- One start bit (0).
- 8 data bits, LSB first.
- One stop bit (1).
- Each bit held exactly DIV cycles, so one frame is 10*DIV cycles.
REQ-009 The first start bit SHALL begin within 4 clocks of reset deassertion.
REQ-010 The next byte's start bit SHALL begin within 2 clocks after the previous stop bit ends.
REQ-011 Sequencer FSM states and transitions:
- IDLE -> LOAD on first clock after reset.
- LOAD -> WAIT: writes banner[idx] to uart_io.
- WAIT -> LOAD when busy falls and idx < 12; idx increments on this transition.
- WAIT -> DONE when busy falls and idx == 12.
- DONE is terminal; uart_tx stays 1.
REQ-012 uart_io handshake: we (1 cycle), data[7:0] in, busy out.
- busy SHALL rise the cycle after an accepted we and stay high through the stop bit.
- A we asserted while busy is high SHALL be ignored.
REQ-013 uart_tx SHALL be registered, with no combinational glitches.
REQ-014 Index arithmetic SHALL be 4 bits with no wrap; DONE prevents idx exceeding 12.

Reset
REQ-015 While reset is high: uart_tx=1, FSM=IDLE, idx=0, busy=0, baud counter=0, bit counter=0.
REQ-016 Reset asserted mid-frame SHALL force uart_tx=1 asynchronously, with no partial-byte completion.
REQ-017 After such a reset the banner SHALL restart from byte 0x48.

Structure
REQ-018 Package host_pkg SHALL hold:
- CLK_HZ default.
- BANNER_LEN=13.
- Banner byte array constant.
- FSM state enum (IDLE, LOAD, WAIT, DONE).
REQ-019 host SHALL instantiate sub-module uart_io as instance uart_io_.
- uart_io contains the 8N1 serializer uart_core as instance uart_core_, carrying parameter BAUD.
- This hierarchy path is fixed so benches can override BAUD.
REQ-020 The banner ROM and sequencer FSM SHALL reside in host.

Verification
REQ-021 Reset held high 1000 cycles -> uart_tx constant 1.
REQ-022 BAUD=500000, release reset -> falling edge within 4 cycles; start bit low 100 cycles; first decoded byte 0x48; stop bit high 100 cycles.
REQ-023 BAUD=500000, run 14000 cycles -> 13 bytes decoded exactly matching the banner; uart_tx then stays 1 for a further 20000 cycles.
REQ-024 Reassert reset during the data bits of byte 5 (0x6F) -> uart_tx=1 in the same cycle; after release the decoded stream restarts at 0x48 and completes all 13 bytes.
REQ-025 Default BAUD=115200 -> start bit width 434 cycles; first byte decodes to 0x48.
REQ-026 Frame timing check at BAUD=500000 -> inter-start-bit spacing between consecutive bytes is 1000–1002 cycles.
